// File: rtl/ysyx_22041461_csr_pkg.sv
// Shared CSR definitions for the trap sequencer: addresses, cause codes,
// mstatus bit positions, FSM states and mstatus update helpers.
package ysyx_22041461_csr_pkg;

   localparam int XLEN = 64;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [XLEN-1:0] CAUSE_ECALL = 64'd11;
   localparam logic [XLEN-1:0] CAUSE_MTI   = 64'h8000_0000_0000_0007;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_T_EPC,
      ST_T_CAUSE,
      ST_T_STATUS,
      ST_T_JUMP,
      ST_R_STATUS,
      ST_R_JUMP
   } trap_state_e;

   // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as previous privilege.
   function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] r;
      r = ms;
      r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
      r[MSTATUS_MIE] = 1'b0;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return r;
   endfunction

   function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] r;
      r = ms;
      r[MSTATUS_MIE] = ms[MSTATUS_MPIE];
      r[MSTATUS_MPIE] = 1'b1;
      r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
      return r;
   endfunction

endpackage

// File: rtl/ysyx_22041461_trap_ctrl.sv
// Trap sequencer owning the machine CSR write port; sequences trap entry/mret.
// Optional timer interrupt path enabled by YSYX_22041461_TIMER_IRQ_EN.
module ysyx_22041461_trap_ctrl
   import ysyx_22041461_csr_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   input  logic            ecall_i,
   input  logic            mret_i,
   input  logic            csr_req_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
`ifdef YSYX_22041461_TIMER_IRQ_EN
   input  logic            mtip_i,
`endif
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   input  logic [XLEN-1:0] mstatus_i,
   output logic            csr_we_o,
   output logic [11:0]     csr_waddr_o,
   output logic [XLEN-1:0] csr_wdata_o,
   output logic            stall_o,
   output logic            redirect_o,
   output logic [XLEN-1:0] redirect_pc_o
);

   trap_state_e     r_state;
   trap_state_e     w_state_next;
   logic [XLEN-1:0] r_epc;
   logic [XLEN-1:0] r_cause;
   logic            w_irq;
   logic            w_trap;
   logic            w_unused;

`ifdef YSYX_22041461_TIMER_IRQ_EN
   assign w_irq = mtip_i & mstatus_i[MSTATUS_MIE];
`else
   assign w_irq = 1'b0;
`endif

   assign w_trap   = w_irq | ecall_i;
   assign w_unused = &{1'b0, mtvec_i[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_epc   <= '0;
         r_cause <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && w_trap) begin
            r_epc   <= pc_i;
            r_cause <= w_irq ? CAUSE_MTI : CAUSE_ECALL;
         end
      end
   end

   always_comb begin
      w_state_next  = r_state;
      csr_we_o      = 1'b0;
      csr_waddr_o   = '0;
      csr_wdata_o   = '0;
      stall_o       = 1'b1;
      redirect_o    = 1'b0;
      redirect_pc_o = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_trap) begin
               w_state_next = ST_T_EPC;
            end else if (mret_i) begin
               w_state_next = ST_R_STATUS;
            end else begin
               stall_o     = 1'b0;
               csr_we_o    = csr_req_i;
               csr_waddr_o = csr_addr_i;
               csr_wdata_o = csr_wdata_i;
            end
         end
         ST_T_EPC: begin
            w_state_next = ST_T_CAUSE;
            csr_we_o     = 1'b1;
            csr_waddr_o  = CSR_MEPC;
            csr_wdata_o  = r_epc;
         end
         ST_T_CAUSE: begin
            w_state_next = ST_T_STATUS;
            csr_we_o     = 1'b1;
            csr_waddr_o  = CSR_MCAUSE;
            csr_wdata_o  = r_cause;
         end
         ST_T_STATUS: begin
            w_state_next = ST_T_JUMP;
            csr_we_o     = 1'b1;
            csr_waddr_o  = CSR_MSTATUS;
            csr_wdata_o  = trap_mstatus(mstatus_i);
         end
         ST_T_JUMP: begin
            w_state_next  = ST_IDLE;
            stall_o       = 1'b0;
            redirect_o    = 1'b1;
            redirect_pc_o = {mtvec_i[XLEN-1:2], 2'b00};
         end
         ST_R_STATUS: begin
            w_state_next = ST_R_JUMP;
            csr_we_o     = 1'b1;
            csr_waddr_o  = CSR_MSTATUS;
            csr_wdata_o  = mret_mstatus(mstatus_i);
         end
         ST_R_JUMP: begin
            w_state_next  = ST_IDLE;
            stall_o       = 1'b0;
            redirect_o    = 1'b1;
            redirect_pc_o = mepc_i;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
      // Reset forces every output quiet in the same cycle it is asserted.
      if (!rst) begin
         w_state_next  = ST_IDLE;
         csr_we_o      = 1'b0;
         csr_waddr_o   = '0;
         csr_wdata_o   = '0;
         stall_o       = 1'b0;
         redirect_o    = 1'b0;
         redirect_pc_o = '0;
      end
   end

endmodule

// File: tb/tb_ysyx_22041461_trap_ctrl.sv
// Directed scoreboard bench for ysyx_22041461_trap_ctrl; timer cases run only
// when YSYX_22041461_TIMER_IRQ_EN is defined.
module tb_ysyx_22041461_trap_ctrl;

   typedef struct packed {
      logic        we;
      logic [11:0] waddr;
      logic [63:0] wdata;
      logic        stall;
      logic        redir;
      logic [63:0] rpc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [63:0] pc_i;
   logic        ecall_i;
   logic        mret_i;
   logic        csr_req_i;
   logic [11:0] csr_addr_i;
   logic [63:0] csr_wdata_i;
   logic        mtip_i;
   logic [63:0] mtvec_i;
   logic [63:0] mepc_i;
   logic [63:0] mstatus_i;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [63:0] csr_wdata_o;
   logic        stall_o;
   logic        redirect_o;
   logic [63:0] redirect_pc_o;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   ysyx_22041461_trap_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .ecall_i      (ecall_i),
      .mret_i       (mret_i),
      .csr_req_i    (csr_req_i),
      .csr_addr_i   (csr_addr_i),
      .csr_wdata_i  (csr_wdata_i),
`ifdef YSYX_22041461_TIMER_IRQ_EN
      .mtip_i       (mtip_i),
`endif
      .mtvec_i      (mtvec_i),
      .mepc_i       (mepc_i),
      .mstatus_i    (mstatus_i),
      .csr_we_o     (csr_we_o),
      .csr_waddr_o  (csr_waddr_o),
      .csr_wdata_o  (csr_wdata_o),
      .stall_o      (stall_o),
      .redirect_o   (redirect_o),
      .redirect_pc_o(redirect_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic we, input logic [11:0] a, input logic [63:0] d,
                               input logic st, input logic rd, input logic [63:0] rpc);
      exp_t e;
      e.we = we; e.waddr = a; e.wdata = d; e.stall = st; e.redir = rd; e.rpc = rpc;
      return e;
   endfunction

   // Inputs are already driven (just after a falling edge); expectation is queued,
   // outputs are sampled 2 time units later, then we move to the next falling edge.
   task automatic cyc(input string tag, input exp_t e);
      exp_t obs;
      exp_t want;
      sb.push_back(e);
      #2;
      obs  = {csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, redirect_o, redirect_pc_o};
      want = sb.pop_front();
      checks++;
      assert (obs === want)
      else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, want);
      end
      $display("txn %s we=%0b addr=%h data=%h stall=%0b redir=%0b rpc=%h",
               tag, csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, redirect_o, redirect_pc_o);
      @(negedge clk);
   endtask

   task automatic quiet_inputs();
      ecall_i = 1'b0; mret_i = 1'b0; csr_req_i = 1'b0; mtip_i = 1'b0;
      csr_addr_i = 12'h0; csr_wdata_i = 64'h0;
   endtask

   localparam logic [63:0] ZERO = 64'h0;

   initial begin
      rst = 1'b0;
      pc_i = 64'h8000_0010; mtvec_i = 64'h8000_0103; mepc_i = 64'h8000_0014;
      mstatus_i = 64'h8;
      quiet_inputs();
      @(negedge clk);

      // Reset held: outputs must be silent even with live requests.
      ecall_i = 1'b1; csr_req_i = 1'b1; csr_addr_i = 12'h305; csr_wdata_i = 64'h1234;
      cyc("rst_hold_a", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      cyc("rst_hold_b", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      quiet_inputs();
      rst = 1'b1;

      cyc("idle_quiet", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      csr_req_i = 1'b1; csr_addr_i = 12'h305; csr_wdata_i = 64'h8000_0200;
      cyc("pass_mtvec", mk(1, 12'h305, 64'h8000_0200, 0, 0, ZERO));
      csr_addr_i = 12'h341; csr_wdata_i = 64'hDEAD_BEEF_0000_1111;
      cyc("pass_mepc", mk(1, 12'h341, 64'hDEAD_BEEF_0000_1111, 0, 0, ZERO));
      csr_req_i = 1'b0;
      cyc("pass_noreq", mk(0, 12'h341, 64'hDEAD_BEEF_0000_1111, 0, 0, ZERO));
      quiet_inputs();

      // ecall: pc changes after T to show the latched epc is used.
      ecall_i = 1'b1; csr_req_i = 1'b1; csr_addr_i = 12'h305; csr_wdata_i = 64'h5555;
      pc_i = 64'h8000_0010;
      cyc("ecall_T", mk(0, 12'h0, ZERO, 1, 0, ZERO));
      pc_i = 64'h0BAD_0BAD;
      cyc("ecall_epc", mk(1, 12'h341, 64'h8000_0010, 1, 0, ZERO));
      cyc("ecall_cause", mk(1, 12'h342, 64'd11, 1, 0, ZERO));
      cyc("ecall_status", mk(1, 12'h300, 64'h1880, 1, 0, ZERO));
      cyc("ecall_jump", mk(0, 12'h0, ZERO, 0, 1, 64'h8000_0100));
      quiet_inputs();
      pc_i = 64'h8000_0100;
      cyc("ecall_after", mk(0, 12'h0, ZERO, 0, 0, ZERO));

      // mret
      mstatus_i = 64'h1880; mepc_i = 64'h8000_0014; mret_i = 1'b1;
      cyc("mret_T", mk(0, 12'h0, ZERO, 1, 0, ZERO));
      cyc("mret_status", mk(1, 12'h300, 64'h88, 1, 0, ZERO));
      cyc("mret_jump", mk(0, 12'h0, ZERO, 0, 1, 64'h8000_0014));
      quiet_inputs();
      cyc("mret_after", mk(0, 12'h0, ZERO, 0, 0, ZERO));

      // Reset asserted while in T_CAUSE aborts the sequence.
      mstatus_i = 64'h8; pc_i = 64'h8000_0040; ecall_i = 1'b1;
      cyc("rstmid_T", mk(0, 12'h0, ZERO, 1, 0, ZERO));
      cyc("rstmid_epc", mk(1, 12'h341, 64'h8000_0040, 1, 0, ZERO));
      rst = 1'b0;
      cyc("rstmid_cause", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      rst = 1'b1; ecall_i = 1'b0;
      cyc("rstmid_idle1", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      cyc("rstmid_idle2", mk(0, 12'h0, ZERO, 0, 0, ZERO));

`ifdef YSYX_22041461_TIMER_IRQ_EN
      // Interrupt beats a simultaneous ecall; epc is the ecall pc.
      mstatus_i = 64'h8; pc_i = 64'h8000_0080; ecall_i = 1'b1; mtip_i = 1'b1;
      cyc("irq_T", mk(0, 12'h0, ZERO, 1, 0, ZERO));
      cyc("irq_epc", mk(1, 12'h341, 64'h8000_0080, 1, 0, ZERO));
      cyc("irq_cause", mk(1, 12'h342, 64'h8000_0000_0000_0007, 1, 0, ZERO));
      cyc("irq_status", mk(1, 12'h300, 64'h1880, 1, 0, ZERO));
      cyc("irq_jump", mk(0, 12'h0, ZERO, 0, 1, 64'h8000_0100));
      ecall_i = 1'b0; mstatus_i = 64'h1880;
      cyc("irq_masked_after", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      mstatus_i = 64'h0;
      cyc("irq_mie_off", mk(0, 12'h0, ZERO, 0, 0, ZERO));
      mtip_i = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop if the sequence above ever stalls.
   initial begin
      #100000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ysyx_22041461_trap_ctrl.md
# ysyx_22041461_trap_ctrl

Multi-cycle trap sequencer that owns the single write port of the machine-mode CSR file (mtvec 0x305, mepc 0x341, mcause 0x342, mstatus 0x300). It arbitrates between instruction CSR writes and trap entry/return, and stalls the core while it writes the CSRs in sequence. On completion it issues a PC redirect. It sits between decode/execute and the CSR file, and its redirect feeds the PC-select logic.

## Interface
- XLEN, 64, data width
- CAUSE_ECALL, 64'd11, mcause value for ecall from M-mode
- CAUSE_MTI, 64'h8000_0000_0000_0007, mcause value for machine timer interrupt
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-low
- pc_i  in  XLEN  PC of the instruction currently in execute
- ecall_i  in  1  execute instruction is ecall; held while stall_o=1
- mret_i  in  1  execute instruction is mret; held while stall_o=1
- csr_req_i  in  1  instruction CSR write request (csrrw/csrrs/...)
- csr_addr_i  in  12  instruction CSR address
- csr_wdata_i  in  XLEN  instruction CSR write data (already computed)
- mtip_i  in  1  timer interrupt pending, level; present only with the macro
- mtvec_i, mepc_i, mstatus_i  in  XLEN  current CSR values tapped from the CSR file
- csr_we_o  out  1  CSR write enable
- csr_waddr_o  out  12  CSR write address
- csr_wdata_o  out  XLEN  CSR write data
- stall_o  out  1  freeze PC/GPR writeback of the current instruction
- redirect_o  out  1  load redirect_pc_o into PC this cycle
- redirect_pc_o  out  XLEN  trap vector or return address

## Operation
- FSM states: IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, R_STATUS, R_JUMP.
- IDLE priority order: interrupt > ecall > mret > csr_req.
  - Interrupt condition: mtip_i & mstatus_i[3].
- IDLE, no trap event:
  - csr_we_o=csr_req_i, waddr/wdata = csr_addr_i/csr_wdata_i, combinational pass-through.
  - stall_o=0.
- IDLE, trap event (interrupt or ecall):
  - stall_o=1, csr_we_o=0.
  - Latch epc_q=pc_i and cause_q (CAUSE_MTI or CAUSE_ECALL).
  - Next state T_EPC.
- T_EPC: write 0x341 <= epc_q.
- T_CAUSE: write 0x342 <= cause_q.
- T_STATUS: write 0x300 <= mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
- T_JUMP:
  - redirect_o=1, redirect_pc_o={mtvec_i[63:2],2'b00}, csr_we_o=0, stall_o=0.
  - Next state IDLE.
- IDLE, mret_i:
  - stall_o=1, next state R_STATUS.
- R_STATUS: write 0x300 <= mstatus_i with MIE=MPIE, MPIE=1, MPP=2'b00.
- R_JUMP:
  - redirect_o=1, redirect_pc_o=mepc_i, stall_o=0.
  - Next state IDLE.
- stall_o=1 in every state except IDLE (no event) and the two JUMP states.
- csr_req_i outside IDLE is ignored; the instruction is either the stalled trap instruction or is flushed by the redirect.
- The interrupted or ecall instruction does not retire. For an interrupt it re-executes after mret.

## Timing
- Reset (rst=0 at an edge) from any state: state=IDLE, epc_q=0, cause_q=0. All registered outputs 0, and all outputs 0 while rst=0.
- Trap latency: event at cycle T, CSR writes at T+1/T+2/T+3, redirect at T+4. PC takes the vector at the T+4 edge. Total 4 stalled cycles (T..T+3).
- mret latency: event at T, mstatus write at T+1, redirect at T+2.
- mstatus_i is read in T_STATUS after the mepc and mcause writes; no bypass is needed since those writes do not touch mstatus.
- ecall and mtip together: interrupt wins, mepc=pc of the ecall.
- mtip stays high after entry: masked because MIE=0 is written at T+3. No re-entry until mret restores MIE.
- No new trap is accepted in the JUMP cycle; evaluation resumes in IDLE on the next cycle.

## Configuration
- YSYX_22041461_TIMER_IRQ_EN defined:
  - mtip_i port exists.
  - Interrupt path and CAUSE_MTI are active.
- YSYX_22041461_TIMER_IRQ_EN undefined:
  - mtip_i port is absent.
  - Interrupt condition is constant 0, and only ecall/mret traps occur.
  - All cycle timing is unchanged.

## Structure
- Shared package ysyx_22041461_csr_pkg holds:
  - CSR address constants (0x300/0x305/0x341/0x342).
  - Cause codes.
  - mstatus bit indices (MIE=3, MPIE=7, MPP=12:11).
  - FSM state enum.
  - Functions trap_mstatus() and mret_mstatus().
- No sub-module; a single FSM with a registered state and combinational outputs.

## Test plan
- Reset mid-sequence:
  - Stimulus: assert rst=0 in T_CAUSE.
  - Response: next cycle state IDLE, all outputs 0, and no further CSR writes.
- ecall:
  - Stimulus: pc_i=0x8000_0010, mtvec_i=0x8000_0103, mstatus_i=0x8.
  - Response: writes mepc=0x8000_0010, mcause=11, then mstatus=0x1880; redirect to 0x8000_0100 at T+4; stall_o high T..T+3.
- mret:
  - Stimulus: mstatus_i=0x1880, mepc_i=0x8000_0014.
  - Response: mstatus write 0x88 at T+1; redirect to 0x8000_0014 at T+2.
- CSR pass-through:
  - Stimulus: csr_req_i=1, addr 0x305, data 0x8000_0200 in IDLE.
  - Response: same-cycle csr_we_o=1 with that addr/data, stall_o=0.
- Timer interrupt (macro on):
  - Stimulus: mtip_i=1 together with ecall_i=1, mstatus_i=0x8.
  - Response: mcause=0x8000_0000_0000_0007, mepc=ecall pc.
  - Stimulus: mtip_i=1 with mstatus_i=0.
  - Response: no trap.
- Macro off:
  - Stimulus: same ecall sequence as above.
  - Response: identical ecall timing.
